fetch_prefetch: RTL and testbench
=================================

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00400020, SHALL be the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, power of two >=2, SHALL be the instruction-queue entry count.
REQ-003 Parameter MAX_OUT, default 2, 1..DEPTH, SHALL be the maximum number of memory requests in flight.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; every state element updates on its rising edge.
- rst_n  in  1  reset: synchronous, active-low, sampled on the rising edge of clk.
- branch  in  1  branch redirect.
- jump  in  1  j/jal redirect.
- jump_reg  in  1  jr redirect; meaningful only when jump=1.
- branch_addr  in  32  branch target.
- jump_addr  in  32  j/jal target.
- jump_reg_addr  in  32  jr target.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address.
- imem_resp_valid  in  1  in-order response; at least 1 cycle after acceptance.
- imem_resp_data  in  32  returned instruction.
- instr_valid  out  1  queue head valid toward decode.
- instr_ready  in  1  decode accepts; the inverse of stallD.
- instr  out  32  head instruction.
- pc_plus_4  out  32  head instruction's PC+4.
- drop_cnt  out  32  discarded-response count; present only under FETCH_PERF_EN.

Function
REQ-005 redirect = branch | jump; target priority SHALL be branch_addr, then jump_reg_addr (jump & jump_reg), then jump_addr.
REQ-006 imem_req_valid SHALL be 1 iff !redirect and outstanding < MAX_OUT and (outstanding + occupancy) < DEPTH.
REQ-007 imem_req_addr SHALL equal fetch_pc; on acceptance (valid & ready), fetch_pc SHALL become fetch_pc + 4 modulo 2^32, so 32'hFFFFFFFC wraps to 0.
REQ-008 imem_req_valid and imem_req_addr SHALL stay stable while imem_req_ready=0.
REQ-009 On redirect, the following SHALL hold the next cycle:
- fetch_pc = target.
- Queue empty.
- drop counter += outstanding, minus one if a response arrives in the redirect cycle.
- outstanding = 0.
REQ-010 A response arriving while the drop counter is nonzero, or in a redirect cycle, SHALL be discarded, decrementing the drop counter when that counter is nonzero.
REQ-011 Any other response SHALL push {imem_resp_data, its request address + 4} into the queue and decrement outstanding.
REQ-012 instr_valid SHALL be (occupancy != 0) & !redirect; instr and pc_plus_4 SHALL come combinationally from the head; a pop SHALL occur on instr_valid & instr_ready.
REQ-013 Push and pop in the same cycle SHALL leave occupancy unchanged and SHALL be legal at full and at empty.
REQ-014 With an empty queue, a response SHALL reach instr_valid the cycle after it arrives: one queue-write cycle, no bypass.
REQ-015 Request acceptance and response in the same cycle SHALL leave outstanding unchanged.
REQ-016 Queue overflow SHALL be impossible by the credit rule in REQ-006; a response arriving with outstanding = 0 is an environment error and SHALL be ignored.
REQ-017 Queue pointers SHALL wrap modulo DEPTH; occupancy SHALL use log2(DEPTH)+1 bits.

Reset
REQ-018 While rst_n=0, the following SHALL hold after the next edge:
- fetch_pc = RESET_PC.
- Queue empty.
- outstanding = 0.
- drop counter = 0.
- drop_cnt = 0.
- imem_req_valid = 0.
- instr_valid = 0.
REQ-019 Reset SHALL override a simultaneous redirect, push or pop; the memory is reset with the same rst_n and returns no responses for pre-reset requests.
REQ-020 imem_req_valid SHALL rise no earlier than the first cycle after rst_n returns to 1.

Configuration
REQ-021 With macro FETCH_PERF_EN defined, drop_cnt SHALL increment by 1 per discarded response, saturating at 32'hFFFFFFFF.
REQ-022 Without FETCH_PERF_EN, port drop_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Reset release, 1-cycle memory, instr_ready=1 -> request addresses 00400020, 00400024, 00400028; pc_plus_4 = 00400024, 00400028, 0040002C, in order.
REQ-024 instr_ready=0 with DEPTH=4 -> exactly 4 instructions queued, imem_req_valid=0, no overflow; raising instr_ready resumes fetch at fetch_pc with no gap or duplicate.
REQ-025 2 requests outstanding, branch=1 with branch_addr=00400100 -> both late responses dropped, instr_valid=0 until data from 00400100 arrives, drop_cnt=2 with FETCH_PERF_EN.
REQ-026 branch=1, jump=1, jump_reg=1 in one cycle -> next request address = branch_addr; jump=1 with jump_reg=1 -> jump_reg_addr; jump=1 with jump_reg=0 -> jump_addr.
REQ-027 jump to FFFFFFFC -> next request address = 00000000.
REQ-028 rst_n=0 mid-stream with 3 queued -> next cycle instr_valid=0, imem_req_valid=0; after release, first request = RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: bounded in-flight fetches feeding an instruction queue, with redirect flush.
// Optional FETCH_PERF_EN macro adds the saturating drop_cnt output.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h00400020,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jump_reg_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] occ_q, occ_d, outst_q, outst_d;
  logic [31:0]     pend_q, pend_d;
  logic            run_q;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc4_mem_q [DEPTH];

  logic        redirect, req_acc, push, pop, resp_drop;
  logic [31:0] target, resp_pc4, drop_sum;
  logic [CntW:0] credit_sum;

  always_comb begin
    redirect   = branch | jump;
    target     = branch ? branch_addr : ((jump & jump_reg) ? jump_reg_addr : jump_addr);
    credit_sum = {1'b0, outst_q} + {1'b0, occ_q};
    // run_q holds requests off until the first cycle after reset release
    imem_req_valid = run_q & ~redirect & (outst_q < CntW'(MAX_OUT))
                     & (credit_sum < (CntW + 1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_acc        = imem_req_valid & imem_req_ready;
    resp_drop      = imem_resp_valid & (redirect | (pend_q != 32'd0));
    push           = imem_resp_valid & ~redirect & (pend_q == 32'd0) & (outst_q != '0);
    instr_valid    = (occ_q != '0) & ~redirect;
    pop            = instr_valid & instr_ready;
    instr          = instr_mem_q[rd_ptr_q];
    pc_plus_4      = pc4_mem_q[rd_ptr_q];
    // Responses are in order, so the oldest live request sits outst_q words behind fetch_pc
    resp_pc4       = fetch_pc_q - (32'(outst_q) << 2) + 32'd4;
    drop_sum       = pend_q + 32'(outst_q);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    pend_d     = pend_q;
    if (redirect) begin
      fetch_pc_d = target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      outst_d    = '0;
      pend_d     = (imem_resp_valid && drop_sum != 32'd0) ? drop_sum - 32'd1 : drop_sum;
    end else begin
      if (req_acc) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid && pend_q != 32'd0) pend_d = pend_q - 32'd1;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      occ_d   = occ_q + CntW'(push) - CntW'(pop);
      outst_d = outst_q + CntW'(req_acc) - CntW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      outst_q    <= '0;
      pend_q     <= 32'd0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      pend_q     <= pend_d;
      run_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_resp_data;
      pc4_mem_q[wr_ptr_q]   <= resp_pc4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (resp_drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= 32'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized scoreboard bench for fetch_prefetch with an in-order memory model and sequential-stream reference.
module tb_fetch_prefetch;

  localparam logic [31:0] RESET_PC = 32'h00400020;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;

  logic        clk, rst_n;
  logic        branch, jump, jump_reg;
  logic [31:0] branch_addr, jump_addr, jump_reg_addr;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc_plus_4;
`ifdef FETCH_PERF_EN
  logic [31:0] drop_cnt;
`endif

  fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch         (branch),
    .jump           (jump),
    .jump_reg       (jump_reg),
    .branch_addr    (branch_addr),
    .jump_addr      (jump_addr),
    .jump_reg_addr  (jump_reg_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_plus_4      (pc_plus_4)
`ifdef FETCH_PERF_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
    logic [31:0] epoch;
  } mreq_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        sb_q[$];
  int          n_cmp, n_fail;
  logic [31:0] cyc, epoch, model_pc, exp_drops;
  logic        prev_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'd0) return 32'hFFFF_FFF8;
    return (r & 32'h0000_FFFC) | 32'h0040_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus plus the memory model; requests are checked and scored at negedge
  task automatic drive_cycle(input bit allow_redir, input int ready_pct, input int iready_pct,
                             input bit force_wrap);
    bit    redir;
    mreq_t r;
    @(posedge clk);
    cyc++;
    #1;
    redir         = force_wrap || (allow_redir && $urandom_range(0, 19) == 0);
    branch        = 1'b0;
    jump          = 1'b0;
    jump_reg      = 1'($urandom_range(0, 1));
    branch_addr   = rand_tgt();
    jump_addr     = rand_tgt();
    jump_reg_addr = rand_tgt();
    if (force_wrap) begin
      jump      = 1'b1;
      jump_reg  = 1'b0;
      jump_addr = 32'hFFFF_FFFC;
    end else if (redir) begin
      case ($urandom_range(0, 3))
        0: begin branch = 1'b1; jump = 1'($urandom_range(0, 1)); end
        1: begin jump = 1'b1; jump_reg = 1'b1; end
        2: begin jump = 1'b1; jump_reg = 1'b0; end
        default: begin branch = 1'b1; jump = 1'b1; jump_reg = 1'b1; end
      endcase
    end
    imem_req_ready  = ($urandom_range(0, 99) < ready_pct);
    instr_ready     = ($urandom_range(0, 99) < iready_pct);
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(r.addr);
      if (redir || r.epoch != epoch) exp_drops++;
    end
    if (redir) begin
      epoch++;
      sb_q.delete();
      if (branch)        model_pc = branch_addr;
      else if (jump_reg) model_pc = jump_reg_addr;
      else               model_pc = jump_addr;
    end
    @(negedge clk);
    if (redir) begin
      check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
      check("instr_valid_in_redirect", 32'(instr_valid), 32'd0);
    end else if (prev_stall) begin
      check("req_valid_held", 32'(imem_req_valid), 32'd1);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(1, 3), epoch: epoch});
      sb_q.push_back('{instr: mem_word(model_pc), pc4: model_pc + 32'd4});
      model_pc = model_pc + 32'd4;
    end
    prev_stall = imem_req_valid & ~imem_req_ready;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    cyc++;
    #1;
    rst_n           = 1'b0;
    branch          = 1'b0;
    jump            = 1'b0;
    imem_resp_valid = 1'b0;
    mem_q.delete();
    sb_q.delete();
    model_pc   = RESET_PC;
    exp_drops  = 32'd0;
    epoch++;
    prev_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      @(negedge clk);
      check("reset_instr_valid", 32'(instr_valid), 32'd0);
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_PERF_EN
      check("reset_drop_cnt", drop_cnt, 32'd0);
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every pop toward decode must match the oldest live expected instruction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc_plus_4 %h expected no instruction", pc_plus_4);
      end else begin
        e = sb_q.pop_front();
        check("instr", instr, e.instr);
        check("pc_plus_4", pc_plus_4, e.pc4);
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; epoch = 0; exp_drops = 0;
    model_pc = RESET_PC; prev_stall = 1'b0;
    rst_n = 1'b0; branch = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    branch_addr = 0; jump_addr = 0; jump_reg_addr = 0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 0; instr_ready = 1'b0;

    do_reset(3);
    repeat (40) drive_cycle(1'b0, 100, 100, 1'b0);

    repeat (30) drive_cycle(1'b0, 100, 0, 1'b0);
    check("req_valid_when_full", 32'(imem_req_valid), 32'd0);
    check("instr_valid_when_full", 32'(instr_valid), 32'd1);
    check("queued_when_full", sb_q.size(), DEPTH);
    repeat (20) drive_cycle(1'b0, 100, 100, 1'b0);

    drive_cycle(1'b0, 100, 100, 1'b1);
    repeat (20) drive_cycle(1'b0, 80, 100, 1'b0);

    repeat (600) drive_cycle(1'b1, 70, 75, 1'b0);

    repeat (12) drive_cycle(1'b0, 100, 0, 1'b0);
    do_reset(2);
    repeat (300) drive_cycle(1'b1, 70, 75, 1'b0);

    repeat (12) drive_cycle(1'b0, 0, 100, 1'b0);
    check("drain_scoreboard_empty", sb_q.size(), 32'd0);
    check("drain_instr_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("drop_cnt", drop_cnt, exp_drops);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
